mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 20 ++
 rtl/mult_div_unit_twos_negate.sv | 12 +
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared arithmetic definitions: operation codes, sequencer states and the
// default iteration count of the iterative multiply/divide datapath.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10
  } md_state_e;

  localparam int MD_ITERS = 32;

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Conditional two's-complement negate: result = en ? -value : value.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = en ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, with sign correction in a final fixup cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             accept, last_step;

  logic             is_div_q, dz_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0] acc_q, mq_q, opb_q;

  logic             in_signed, in_div, in_dz, sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH:0]   mul_sum, div_part, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] lo_neg, hi_neg, hi_fix, lo_fix;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign in_dz     = in_div && (input_b == '0);
  assign sign_a    = in_signed && input_a[WIDTH-1];
  assign sign_b    = in_signed && input_b[WIDTH-1];

  twos_negate #(.WIDTH(WIDTH)) u_abs_a (.en(sign_a), .value(input_a), .result(abs_a));
  twos_negate #(.WIDTH(WIDTH)) u_abs_b (.en(sign_b), .value(input_b), .result(abs_b));

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_step = (state_q == ST_RUN) && (count_q == CNT_W'(WIDTH - 1));
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = in_dz ? ST_FIXUP : ST_RUN;
      ST_RUN:   if (last_step) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == ST_FIXUP);
      if (accept) begin
        count_q     <= '0;
        div_by_zero <= 1'b0;
      end else if (state_q == ST_RUN) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (state_q == ST_FIXUP) begin
        hi          <= hi_fix;
        lo          <= lo_fix;
        div_by_zero <= dz_q;
      end
    end
  end

  // Per-step arithmetic: {acc,mq} is the product shifter for multiply and
  // {remainder,dividend/quotient} shifter for divide.
  assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
  assign div_part = {acc_q, mq_q[WIDTH-1]};
  assign div_ge   = (div_part >= {1'b0, opb_q});
  assign div_diff = div_part - {1'b0, opb_q};

  always_ff @(posedge clock) begin
    if (accept) begin
      is_div_q <= in_div;
      dz_q     <= in_dz;
      neg_lo_q <= sign_a ^ sign_b;
      neg_hi_q <= in_div ? sign_a : (sign_a ^ sign_b);
      opb_q    <= abs_b;
      acc_q    <= '0;
      mq_q     <= in_dz ? input_a : abs_a;
    end else if (state_q == ST_RUN) begin
      if (is_div_q) begin
        acc_q <= div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
        mq_q  <= {mq_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= mul_sum[WIDTH:1];
        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  // Sign fixup: a negated 2*WIDTH product only borrows into hi when lo is zero.
  twos_negate #(.WIDTH(WIDTH)) u_fix_lo (.en(neg_lo_q), .value(mq_q),  .result(lo_neg));
  twos_negate #(.WIDTH(WIDTH)) u_fix_hi (.en(neg_hi_q), .value(acc_q), .result(hi_neg));

  always_comb begin
    hi_fix = hi_neg;
    lo_fix = lo_neg;
    if (dz_q) begin
      hi_fix = mq_q;
      lo_fix = '1;
    end else if (!is_div_q && neg_hi_q && (mq_q != '0)) begin
      hi_fix = ~acc_q;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: result vectors, latency, busy/done
// framing, divide-by-zero, ignored starts and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .input_a(input_a), .input_b(input_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    op = o; input_a = a; input_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Returns edges seen until done is visible; gap flags a cycle with neither busy nor done.
  task automatic wait_done(output int edges, output bit overlap, output bit gap);
    edges = 0; overlap = 0; gap = 0;
    while (!done && edges < 60) begin
      if (!busy) gap = 1;
      @(posedge clock); #1;
      edges++;
      if (busy && done) overlap = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_by_zero); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h_%h want=0", hi, lo); end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t v);
    int n; bit ov, gp;
    start_op(v.op, v.a, v.b);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_e0 got=%b want=1", name, busy); end
    wait_done(n, ov, gp);
    total++; if (n != 33) begin bad++; $display("FAIL %s_latency got=%0d want=33", name, n); end
    total++; if (ov || gp || busy !== 1'b0) begin bad++; $display("FAIL %s_framing overlap=%b gap=%b busy=%b want 0/0/0", name, ov, gp, busy); end
    total++; if (hi !== v.ehi || lo !== v.elo) begin bad++; $display("FAIL %s_result got=%h_%h want=%h_%h", name, hi, lo, v.ehi, v.elo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL %s_dz got=%b want=0", name, div_by_zero); end
  endtask

  task automatic test_mult();
    vec_t mv[9];
    mv[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    mv[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    mv[2] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    mv[3] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mv[4] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    mv[5] = '{OP_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    mv[6] = '{OP_MULT,  32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'hFFFF0000};
    mv[7] = '{OP_MULT,  32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000};
    mv[8] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    for (int i = 0; i < 9; i++) run_table($sformatf("mult%0d", i), mv[i]);
  endtask

  task automatic test_div();
    vec_t dv[8];
    dv[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    dv[1] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    dv[2] = '{OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    dv[3] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    dv[4] = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    dv[5] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    dv[6] = '{OP_DIVU, 32'h00000005, 32'h00000010, 32'h00000005, 32'h00000000};
    dv[7] = '{OP_DIV,  32'h00000006, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFE};
    for (int i = 0; i < 8; i++) run_table($sformatf("div%0d", i), dv[i]);
  endtask

  task automatic test_div_by_zero();
    int n; bit ov, gp;
    start_op(OP_DIVU, 32'h00000064, 32'h0);
    wait_done(n, ov, gp);
    total++; if (n != 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", n); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
    total++; if (hi !== 32'h64 || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_result got=%h_%h want=00000064_ffffffff", hi, lo); end
    repeat (3) @(posedge clock); #1;
    total++; if (div_by_zero !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL dz_hold dz=%b done=%b want 1/0", div_by_zero, done); end
    start_op(OP_DIV, 32'hFFFFFFF0, 32'h0);
    wait_done(n, ov, gp);
    total++; if (n != 1 || div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_signed lat=%0d dz=%b want 1/1", n, div_by_zero); end
    total++; if (hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_signed_result got=%h_%h want=fffffff0_ffffffff", hi, lo); end
    start_op(OP_DIVU, 32'h9, 32'h3);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", div_by_zero); end
    repeat (10) @(posedge clock); #1;
    total++; if (hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL hilo_hold got=%h_%h want=fffffff0_ffffffff", hi, lo); end
    wait_done(n, ov, gp);
    total++; if (hi !== 32'h0 || lo !== 32'h3) begin bad++; $display("FAIL div_after_dz got=%h_%h want=0_3", hi, lo); end
  endtask

  task automatic test_ignore_start();
    int n, pulses; bit ov, gp;
    start_op(OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(posedge clock);
    start_op(OP_MULTU, 32'd7, 32'd9);
    wait_done(n, ov, gp);
    total++; if (n != 28) begin bad++; $display("FAIL ignore_latency got=%0d want=28", n); end
    total++; if (hi !== 32'h0 || lo !== 32'd15) begin bad++; $display("FAIL ignore_result got=%h_%h want=0_f", hi, lo); end
    pulses = 0;
    repeat (40) begin @(posedge clock); #1; if (done || busy) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL ignore_second got=%0d busy/done cycles want=0", pulses); end
  endtask

  task automatic test_reset_mid_op();
    int n; bit ov, gp;
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'h2);
    repeat (4) @(posedge clock);
    start_op(OP_MULTU, 32'h11, 32'h22);
    repeat (5) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_ctrl busy=%b done=%b want 0/0", busy, done); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL midreset_hilo got=%h_%h want=0", hi, lo); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_nodone done=%b busy=%b want 0/0", done, busy); end
    @(negedge clock);
    reset = 1'b0; op = OP_MULTU; input_a = 32'd6; input_b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL postreset_accept got=%b want=1", busy); end
    wait_done(n, ov, gp);
    total++; if (n != 33 || hi !== 32'h0 || lo !== 32'd42) begin bad++; $display("FAIL postreset_result lat=%0d got=%h_%h want 33 0_2a", n, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n; bit ov, gp;
    start_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    wait_done(n, ov, gp);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL b2b_first got=%h_%h want=ffffffff_fffffffa", hi, lo); end
    start_op(OP_DIVU, 32'd1000, 32'd33);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_done(n, ov, gp);
    total++; if (n != 33 || hi !== 32'd10 || lo !== 32'd30) begin bad++; $display("FAIL b2b_second lat=%0d got=%h_%h want 33 a_1e", n, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
